// File: rtl/single_wire_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : single_wire_io_sequencer
// Description : Bit-serial sequencer for one bidirectional pin. A write
//               drives WIDTH bits MSB first, checks each driven bit against
//               the synchronized pin, and then releases the bus for a
//               turnaround period. A read samples WIDTH bits from the pin
//               and returns them as a parallel word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        bits per transaction (1..32)
//   CLKS_PER_BIT clock cycles per bit period (3..255)
//   TURN_BITS    bit periods of released bus after a write (1..15)
// Ports
//   CLK        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (IDLE only)
//   req_write  in   1 = write (drive pin), 0 = read (sample pin)
//   req_data   in   write payload, MSB sent first
//   rsp_valid  out  one-cycle pulse, read data available
//   rsp_data   out  read payload, first sampled bit in MSB
//   dout       out  pin output data (I/O cell D_OUT_0)
//   dout_en    out  pin output enable (I/O cell OUTPUT_ENABLE)
//   din        in   raw pin input (I/O cell D_IN_0), asynchronous to CLK
//   collision  out  one-cycle pulse, a driven bit was read back wrong
// ============================================================================
module single_wire_io_sequencer #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int TURN_BITS    = 1
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_data,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic             dout,
   output logic             dout_en,
   input  logic             din,
   output logic             collision
);

   // Counter widths cover the largest legal parameter values.
   localparam int CYC_W = 8;
   localparam int BIT_W = 6;

   localparam logic [CYC_W-1:0] LAST_CYC      = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_TURN_BIT = BIT_W'(TURN_BITS - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_TURN   = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             sync_meta;
   logic             din_s;
   logic [CYC_W-1:0] cyc_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shift_in;
   logic             accept;
   logic             bit_end;
   logic             data_done;
   logic             turn_done;
   logic             mismatch;

   // ------------------------------------------------------------------------
   // Pin input synchronizer
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         din_s     <= 1'b0;
      end else begin
         sync_meta <= din;
         din_s     <= sync_meta;
      end
   end

   // ------------------------------------------------------------------------
   // Bit-timing decodes
   // ------------------------------------------------------------------------
   assign accept    = req_valid && req_ready;
   assign bit_end   = (cyc_cnt == LAST_CYC);
   assign data_done = bit_end && (bit_cnt == LAST_DATA_BIT);
   assign turn_done = bit_end && (bit_cnt == LAST_TURN_BIT);
   // The synchronizer lags the pin by two cycles; with at least three cycles
   // per bit the synchronized value reflects the current bit by its last cycle.
   assign mismatch  = bit_end && (din_s != shreg[WIDTH-1]);

   // Shift register value with the synchronized pin appended at the LSB.
   generate
      if (WIDTH == 1) begin : g_shift_narrow
         assign shift_in = din_s;
      end else begin : g_shift_wide
         assign shift_in = {shreg[WIDTH-2:0], din_s};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = req_write ? ST_DRIVE : ST_SAMPLE;
            end
         end
         ST_DRIVE: begin
            // A wrong read-back aborts the remaining bits straight into TURN.
            if (mismatch || data_done) begin
               state_next = ST_TURN;
            end
         end
         ST_SAMPLE: begin
            if (data_done) begin
               state_next = ST_IDLE;
            end
         end
         ST_TURN: begin
            if (turn_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      req_ready = 1'b0;
      dout_en   = 1'b0;
      dout      = 1'b0;
      collision = 1'b0;
      case (state)
         ST_IDLE: begin
            // Held low for the whole reset pulse, not only until the
            // asynchronous clear of the state register.
            req_ready = !reset;
         end
         ST_DRIVE: begin
            dout_en   = 1'b1;
            dout      = shreg[WIDTH-1];
            collision = mismatch;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bit and cycle counters: both restart whenever the state changes, so
   // every entry into DRIVE, SAMPLE or TURN begins at bit 0, cycle 0.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cyc_cnt <= '0;
         bit_cnt <= '0;
      end else if (state_next != state) begin
         cyc_cnt <= '0;
         bit_cnt <= '0;
      end else if (state != ST_IDLE) begin
         if (bit_end) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
         end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shared shift register: loaded with the payload on a write, filled from
   // the pin on a read. Its MSB is always the bit currently on the wire.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         shreg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg <= req_data;
               end
            end
            ST_DRIVE: begin
               if (bit_end) begin
                  shreg <= shreg << 1;
               end
            end
            ST_SAMPLE: begin
               if (bit_end) begin
                  shreg <= shift_in;
               end
            end
            default: begin
               shreg <= shreg;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read response: the final sample goes straight into rsp_data so the
   // word is complete in the first IDLE cycle, alongside the rsp_valid pulse.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= (state == ST_SAMPLE) && data_done;
         if ((state == ST_SAMPLE) && data_done) begin
            rsp_data <= shift_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_single_wire_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_wire_io_sequencer
// Description : Self-checking bench. A transaction-level model predicts the
//               pin and handshake outputs from cycles elapsed since request
//               acceptance; directed transactions pin the model with
//               hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_wire_io_sequencer;

   localparam int W = 8;
   localparam int C = 4;
   localparam int T = 1;

   logic         CLK = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [W-1:0] req_data = '0;
   logic         rsp_valid;
   logic [W-1:0] rsp_data;
   logic         dout;
   logic         dout_en;
   logic         din;
   logic         collision;

   int checks = 0;
   int failures = 0;

   // Pin environment
   logic         loopback = 1'b1;
   logic         din_const = 1'b0;
   logic [W-1:0] rd_pat = '0;
   logic         use_pat = 1'b0;
   logic         pat_bit = 1'b0;

   // Transaction model state
   logic [1:0]   m_busy = 2'd0;     // 0 idle, 1 write, 2 read
   int           m_k = 0;           // cycles since acceptance
   int           m_end_k = 0;       // last busy cycle
   int           m_drive_len = 0;   // cycles with the pin driven
   int           m_coll_k = 0;      // cycle of collision, 0 = none
   logic [W-1:0] m_data = '0;
   logic         m_rsp_pulse = 1'b0;
   logic [W-1:0] m_rsp_data = '0;

   logic         exp_drv;
   int           exp_idx;
   logic         exp_dout;
   logic         exp_coll;
   logic         exp_ready;

   always #5 CLK = ~CLK;

   assign din = use_pat ? pat_bit : (loopback ? dout : din_const);

   single_wire_io_sequencer #(
      .WIDTH       (W),
      .CLKS_PER_BIT(C),
      .TURN_BITS   (T)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_data (req_data),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .dout     (dout),
      .dout_en  (dout_en),
      .din      (din),
      .collision(collision)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle (counted from acceptance) at which a write to d collides, 0 if none.
   function automatic int coll_k_of(input logic [W-1:0] d);
      int r;
      r = 0;
      if (!loopback) begin
         for (int b = W - 1; b >= 0; b--) begin
            if (r == 0 && d[b] != din_const) r = (W - b) * C;
         end
      end
      return r;
   endfunction

   function automatic int drive_len_of(input logic [W-1:0] d);
      return (coll_k_of(d) != 0) ? coll_k_of(d) : W * C;
   endfunction

   // ------------------------------------------------------------------------
   // Transaction model
   // ------------------------------------------------------------------------
   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         m_busy      <= 2'd0;
         m_k         <= 0;
         m_rsp_pulse <= 1'b0;
         m_rsp_data  <= '0;
      end else begin
         m_rsp_pulse <= 1'b0;
         if (m_busy == 2'd0) begin
            if (req_valid) begin
               m_busy      <= req_write ? 2'd1 : 2'd2;
               m_k         <= 1;
               m_data      <= req_write ? req_data : rd_pat;
               m_coll_k    <= req_write ? coll_k_of(req_data) : 0;
               m_drive_len <= req_write ? drive_len_of(req_data) : 0;
               m_end_k     <= req_write ? drive_len_of(req_data) + T * C : W * C;
            end
         end else if (m_k == m_end_k) begin
            if (m_busy == 2'd2) begin
               m_rsp_pulse <= 1'b1;
               m_rsp_data  <= m_data;
            end
            m_busy <= 2'd0;
            m_k    <= 0;
         end else begin
            m_k <= m_k + 1;
         end
      end
   end

   assign exp_drv   = (m_busy == 2'd1) && (m_k >= 1) && (m_k <= m_drive_len);
   assign exp_idx   = (m_busy != 2'd0 && m_k >= 1 && m_k <= W * C) ? (W - 1 - ((m_k - 1) / C)) : 0;
   assign exp_dout  = exp_drv ? m_data[exp_idx] : 1'b0;
   assign exp_coll  = (m_busy == 2'd1) && (m_coll_k != 0) && (m_k == m_coll_k);
   assign exp_ready = (m_busy == 2'd0) && !reset;

   // Read pattern placed on the pin, one bit per bit period from SAMPLE entry.
   always @(negedge CLK) begin
      use_pat <= (m_busy == 2'd2);
      pat_bit <= (m_busy == 2'd2) ? m_data[exp_idx] : 1'b0;
   end

   // ------------------------------------------------------------------------
   // Per-cycle compare
   // ------------------------------------------------------------------------
   always @(negedge CLK) begin
      chk("req_ready", req_ready, exp_ready);
      chk("dout_en", dout_en, exp_drv);
      chk("dout", dout, exp_dout);
      chk("collision", collision, exp_coll);
      chk("rsp_valid", rsp_valid, m_rsp_pulse);
      chk("rsp_data", rsp_data, m_rsp_data);
   end

   // One request, then observe until req_ready returns.
   task automatic run_txn(input logic wr, input logic [W-1:0] d,
                          output int en_cnt, output int coll_cnt, output int coll_at,
                          output int rsp_cnt, output int rsp_at, output int ready_at,
                          output logic [W-1:0] bits);
      en_cnt = 0; coll_cnt = 0; coll_at = -1; rsp_cnt = 0; rsp_at = -1;
      ready_at = -1; bits = '0;
      @(negedge CLK); #1;
      req_valid = 1'b1; req_write = wr; req_data = d;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_write = 1'b0; req_data = '0;
      for (int k = 1; k <= 200 && ready_at < 0; k++) begin
         @(negedge CLK);
         if (dout_en) en_cnt++;
         if (collision) begin coll_cnt++; coll_at = k; end
         if (rsp_valid) begin rsp_cnt++; rsp_at = k; end
         if ((k % C) == 2 && k <= W * C) bits = {bits[W-2:0], dout};
         if (req_ready) ready_at = k;
      end
      if (ready_at < 0) chk("txn_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at;
      logic [W-1:0] bits;
      logic got;
      int b2b_at;
      logic [W-1:0] b2b_data;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_dout_en", dout_en, 1'b0);
      chk("rst_dout", dout, 1'b0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      #1 reset = 1'b0;
      #1 chk("rst_release_ready", req_ready, 1'b1);

      // Write 0xA5 with loopback
      loopback = 1'b1;
      run_txn(1'b1, 8'hA5, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("wA5_en_cycles", en_cnt, 32);
      chk("wA5_ready_at", ready_at, 37);
      chk("wA5_collisions", coll_cnt, 0);
      chk("wA5_bits", bits, 8'hA5);

      // Read 0x3C
      loopback = 1'b0;
      rd_pat = 8'h3C;
      run_txn(1'b0, 8'h00, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("r3C_rsp_count", rsp_cnt, 1);
      chk("r3C_rsp_at", rsp_at, 33);
      chk("r3C_rsp_data", rsp_data, 8'h3C);
      chk("r3C_en_cycles", en_cnt, 0);

      // Write 0xFF against a pin stuck at 0: collision at bit 0
      din_const = 1'b0;
      repeat (3) @(negedge CLK);
      run_txn(1'b1, 8'hFF, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("wFF_coll_count", coll_cnt, 1);
      chk("wFF_coll_at", coll_at, 4);
      chk("wFF_en_cycles", en_cnt, 4);
      chk("wFF_ready_at", ready_at, 9);
      chk("wFF_rsp_count", rsp_cnt, 0);

      // Write 0x30 against 0: collision at bit 2
      run_txn(1'b1, 8'h30, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("w30_coll_at", coll_at, 12);
      chk("w30_ready_at", ready_at, 17);

      // Write 0xFF against a pin held at 1: no collision, full length
      din_const = 1'b1;
      repeat (3) @(negedge CLK);
      run_txn(1'b1, 8'hFF, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("wFFhi_coll_count", coll_cnt, 0);
      chk("wFFhi_en_cycles", en_cnt, 32);

      // Reset during bit 3 of a write
      loopback = 1'b1;
      @(negedge CLK); #1;
      req_valid = 1'b1; req_write = 1'b1; req_data = 8'hA5;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_write = 1'b0; req_data = '0;
      repeat (14) @(negedge CLK);
      chk("mid_write_en", dout_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_dout_en", dout_en, 1'b0);
      chk("async_rst_dout", dout, 1'b0);
      chk("async_rst_ready", req_ready, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      #1 reset = 1'b0;
      #1 chk("post_rst_ready", req_ready, 1'b1);
      rd_pat = 8'h81;
      run_txn(1'b0, 8'h00, en_cnt, coll_cnt, coll_at, rsp_cnt, rsp_at, ready_at, bits);
      chk("r81_rsp_at", rsp_at, 33);
      chk("r81_rsp_data", rsp_data, 8'h81);
      chk("r81_coll_count", coll_cnt, 0);

      // Back-to-back: write 0x0F, then a read held pending through the write
      rd_pat = 8'h5A;
      got = 1'b0;
      b2b_at = -1;
      b2b_data = '0;
      @(negedge CLK); #1;
      req_valid = 1'b1; req_write = 1'b1; req_data = 8'h0F;
      @(posedge CLK);
      for (int k = 1; k <= 200 && !got; k++) begin
         @(negedge CLK);
         if (rsp_valid) begin
            got = 1'b1;
            b2b_at = k;
            b2b_data = rsp_data;
         end else begin
            #1;
            if (k <= 10) begin
               req_valid = 1'($urandom_range(0, 1));
               req_write = 1'($urandom_range(0, 1));
               req_data  = W'($urandom);
            end else begin
               req_valid = 1'b1;
               req_write = 1'b0;
            end
         end
      end
      #1 req_valid = 1'b0;
      req_write = 1'b0;
      chk("b2b_rsp_at", b2b_at, 70);
      chk("b2b_rsp_data", b2b_data, 8'h5A);
      repeat (4) @(negedge CLK);
      chk("b2b_idle_ready", req_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/single_wire_io_sequencer.md
SINGLE_WIRE_IO_SEQUENCER -- requirements
Module: single_wire_io_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, bits per transaction; legal range 1..32.
REQ-002 Parameter: CLKS_PER_BIT, 4, CLK cycles per bit period; legal range 3..255.
REQ-003 Parameter: TURN_BITS, 1, bit periods of released bus after a write; legal range 1..15.
REQ-004 Port: CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  1  request present.
REQ-007 Port: req_ready  output  1  sequencer can accept a request this cycle.
REQ-008 Port: req_write  input  1  1 = write (drive pin), 0 = read (sample pin).
REQ-009 Port: req_data  input  WIDTH  write payload, MSB sent first.
REQ-010 Port: rsp_valid  output  1  one-cycle pulse: read data available.
REQ-011 Port: rsp_data  output  WIDTH  read payload, first sampled bit in MSB.
REQ-012 Port: dout  output  1  pin output data; connects to the I/O cell's D_OUT_0.
REQ-013 Port: dout_en  output  1  pin output enable; connects to the I/O cell's OUTPUT_ENABLE.
REQ-014 Port: din  input  1  raw pin input from the I/O cell's D_IN_0, asynchronous to CLK.
REQ-015 Port: collision  output  1  one-cycle pulse: driven bit read back wrong.

Function
REQ-016 The block SHALL pass din through a 2-flop synchronizer; "din_s" below means the second flop's output.
REQ-017 States SHALL be IDLE, DRIVE, SAMPLE, TURN; req_ready SHALL equal 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_* SHALL be captured at that edge and ignored at all other times.
REQ-019 Acceptance SHALL move IDLE->DRIVE when req_write=1, and IDLE->SAMPLE when req_write=0, effective the next cycle.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles; a bit counter and a cycle counter SHALL both restart at 0 on entry to DRIVE, SAMPLE or TURN.
REQ-021 DRIVE: dout_en=1; dout SHALL equal the current bit, MSB first, held constant for the whole bit period.
REQ-022 DRIVE check: on the last cycle of each bit, if din_s != dout, collision SHALL pulse high for one cycle and the next state SHALL be TURN, aborting the remaining bits.
REQ-023 DRIVE completion: after WIDTH bits with no collision, the next state SHALL be TURN.
REQ-024 TURN: dout_en=0 and dout=0 for TURN_BITS*CLKS_PER_BIT cycles, then the next state SHALL be IDLE.
REQ-025 SAMPLE: dout_en=0; din_s SHALL be shifted in on the last cycle of each bit period.
REQ-026 SAMPLE completion: after WIDTH bits the next state SHALL be IDLE, with rsp_valid=1 for exactly that first IDLE cycle.
REQ-027 rsp_data SHALL update only at read completion and hold its value until the next read completes.
REQ-028 IDLE: dout_en=0 and dout=0.
REQ-029 Reads SHALL have no turnaround; a read may be accepted in the first IDLE cycle.
REQ-030 Write latency: from the acceptance edge, dout_en SHALL be high for exactly WIDTH*CLKS_PER_BIT cycles (no collision), followed by TURN_BITS*CLKS_PER_BIT cycles in TURN.
REQ-031 rsp_valid and collision SHALL never be high in the same cycle.

Reset
REQ-032 Asserting reset SHALL immediately, without waiting for a clock edge, force: state=IDLE, dout_en=0, dout=0, rsp_valid=0, rsp_data=0, collision=0, counters=0, synchronizer flops=0.
REQ-033 While reset is high, req_ready SHALL be 0; it SHALL rise in the first cycle after reset deasserts.
REQ-034 A reset mid-transaction SHALL discard the transaction: no rsp_valid, no collision, and no TURN period.

Verification
REQ-035 Write 0xA5 (defaults), din looped back from dout: dout_en high 32 cycles; dout bit sequence 1,0,1,0,0,1,0,1, each held 4 cycles; then 4 TURN cycles; req_ready returns 37 cycles after acceptance; collision never asserts.
REQ-036 Read, bench drives din=0x3C MSB first, 4 cycles per bit, aligned to SAMPLE entry: rsp_valid pulses once, 33 cycles after acceptance, with rsp_data=0x3C; dout_en stays 0 throughout.
REQ-037 Write 0xFF with din held at 0: collision pulses once at bit 0; dout_en falls the next cycle; 4 TURN cycles follow; then IDLE; rsp_valid stays 0.
REQ-038 Reset asserted during bit 3 of a write: dout_en=0 with no clock edge required; after release, req_ready=1 and a following read of 0x81 returns 0x81.
REQ-039 Back-to-back: req_valid held high with write 0x0F then read; the read is accepted exactly on the first IDLE cycle after TURN; req_valid toggling while busy has no effect.
